tpu_result_drain: RTL and testbench
===================================

# tpu_result_drain

Downstream stage of the TPU top level. Captures the quantized result rows the TPU writes to its three comparison SRAM ports (a, b, c), buffers them in a small FIFO and streams them out as a valid/ready word stream, one header word plus the row data per captured write. Signals completion once the TPU reports done and every captured row has been streamed.

## Interface

**Parameters**
- `ARRAY_SIZE`, 8: lanes per result row.
- `OUTPUT_DATA_WIDTH`, 16: bits per lane.
- `OUT_WIDTH`, 32: stream word width. `ARRAY_SIZE*OUTPUT_DATA_WIDTH` must be a multiple of `OUT_WIDTH`. `BEATS = ARRAY_SIZE*OUTPUT_DATA_WIDTH/OUT_WIDTH`, which is 4 at the defaults.
- `FIFO_DEPTH`, 4: row entries buffered. Must be a power of two, at least 2.

**Ports** (`RW = ARRAY_SIZE*OUTPUT_DATA_WIDTH`)
- `clk`, in, 1: single clock, rising edge.
- `srstn`, in, 1: asynchronous, active-low reset.
- `sram_write_enable_a0` / `_b0` / `_c0`, in, 1 each: row write strobes from the TPU.
- `sram_wdata_a` / `_b` / `_c`, in, RW each: row data.
- `sram_waddr_a` / `_b` / `_c`, in, 6 each: row address.
- `tpu_done`, in, 1: TPU completion. A level or a pulse is accepted; the block latches it.
- `m_valid`, out, 1: stream word valid.
- `m_ready`, in, 1: stream sink ready.
- `m_data`, out, OUT_WIDTH: stream word.
- `m_last`, out, 1: marks the final data beat of a row.
- `drain_done`, out, 1: one-cycle completion pulse.
- `overflow`, out, 1: sticky flag, a row was dropped because the FIFO was full.
- `collision`, out, 1: sticky flag, more than one write strobe was high in the same cycle.

## Operation

**Capture**
- Each cycle, at most one strobe is taken. Priority is a > b > c.
- A FIFO entry is {bank[1:0], addr[5:0], data[RW-1:0]}, with bank a=0, b=1, c=2.
- If two or more strobes are high in the same cycle, only the highest-priority one is pushed and `collision` is set.
- Push when full:
  - If a pop completes in the same cycle, the push is accepted.
  - Otherwise the row is dropped, `overflow` is set and FIFO contents are unchanged.

**Stream FSM**
- States are IDLE, HDR and DATA.
- IDLE:
  - If the FIFO is non-empty, go to HDR.
  - `m_valid` is 0 in IDLE.
- HDR:
  - `m_valid`=1, `m_last`=0.
  - `m_data` = {8'hA5, 14'b0, bank[1:0], 2'b0, addr[5:0]}, zero-extended or truncated to the low OUT_WIDTH bits. At the default width this is exactly 32 bits.
  - On `m_valid && m_ready`, go to DATA with beat counter k=0.
- DATA:
  - `m_data` = row data[OUT_WIDTH*k +: OUT_WIDTH]; lane 0 goes out first, low bits first.
  - `m_last` = (k == BEATS-1).
  - On handshake with k < BEATS-1, increment k.
  - On handshake at k == BEATS-1, pop the FIFO. Then go to HDR if another entry remains after the pop, else go to IDLE.
- Stream outputs are driven from the FIFO head and FSM registers. They hold stable while `m_valid && !m_ready`.

**Completion**
- `tpu_done` sets a sticky `done_seen` register.
- `drain_done` pulses high for exactly one cycle when all of the following hold: `done_seen`=1, FIFO empty, FSM in IDLE, and no strobe high this cycle.
- The same cycle `drain_done` pulses, `done_seen` clears.
- `overflow` and `collision` clear only on reset.

## Timing

- **Reset values:** `m_valid`=0, `m_last`=0, `m_data`=0, `drain_done`=0, `overflow`=0, `collision`=0. FIFO is empty, FSM is in IDLE, `done_seen`=0. Reset is asynchronous assert and synchronous deassert. Asserting reset mid-row discards all buffered rows with no partial flush.
- **Latency:** a strobe sampled at edge N gives `m_valid`=1 with the header after edge N+1, when the FIFO was empty and the FSM idle.
- **Throughput:** with `m_ready` held high, one row takes 1+BEATS cycles. Back-to-back rows have no idle cycle, so DATA goes directly to HDR.
- **Capacity:** the FIFO holds FIFO_DEPTH rows. Pointers wrap modulo FIFO_DEPTH. Occupancy is a log2(FIFO_DEPTH)+1-bit counter.
- **Completion timing:** `drain_done` asserts at the earliest one cycle after the pop of the last row.

## Test plan

1. **Single row.** Pulse a0 with addr=5, data lane i=i+1, `m_ready`=1.
   - Required words: 0xA5000005, 0x00020001, 0x00040003, 0x00060005, 0x00080007.
   - `m_last` high on the fifth word only.
   - The header appears the cycle after the strobe.
2. **Backpressure.** Same row with `m_ready` toggling 1,0,0,1,...
   - Each word stays stable while stalled.
   - No word is skipped or duplicated.
   - 5 handshakes total.
3. **Overflow.** `m_ready`=0, strobe b0 on 5 consecutive cycles with addr 0..4.
   - FIFO holds addr 0..3 and `overflow`=1.
   - After releasing ready, exactly 4 rows stream, bank=1, in order.
4. **Collision.** a0 and c0 high in the same cycle, addr 7 and addr 9.
   - Only a bank-0, addr-7 row is streamed.
   - `collision`=1.
5. **Full with simultaneous pop.** FIFO full; the final data beat handshakes in the same cycle as a new strobe.
   - The new row is accepted and streamed last.
   - `overflow` stays 0.
6. **Completion and reset.**
   - `tpu_done` pulse while 2 rows are buffered: `drain_done` pulses once, one cycle after the second row's last beat.
   - `srstn` asserted mid-row: all outputs return to 0 immediately and no `drain_done` follows.

Source files
------------

// File: rtl/tpu_result_drain.sv
// Result drain: captures TPU result-row writes from banks a/b/c into a small FIFO
// and streams each as a header word plus BEATS data words over valid/ready.
module tpu_result_drain #(
    parameter int unsigned ARRAY_SIZE        = 8,
    parameter int unsigned OUTPUT_DATA_WIDTH = 16,
    parameter int unsigned OUT_WIDTH         = 32,
    parameter int unsigned FIFO_DEPTH        = 4
) (
    input  logic                                      clk,
    input  logic                                      srstn,
    input  logic                                      sram_write_enable_a0,
    input  logic                                      sram_write_enable_b0,
    input  logic                                      sram_write_enable_c0,
    input  logic [ARRAY_SIZE*OUTPUT_DATA_WIDTH-1:0]   sram_wdata_a,
    input  logic [ARRAY_SIZE*OUTPUT_DATA_WIDTH-1:0]   sram_wdata_b,
    input  logic [ARRAY_SIZE*OUTPUT_DATA_WIDTH-1:0]   sram_wdata_c,
    input  logic [5:0]                                sram_waddr_a,
    input  logic [5:0]                                sram_waddr_b,
    input  logic [5:0]                                sram_waddr_c,
    input  logic                                      tpu_done,
    output logic                                      m_valid,
    input  logic                                      m_ready,
    output logic [OUT_WIDTH-1:0]                      m_data,
    output logic                                      m_last,
    output logic                                      drain_done,
    output logic                                      overflow,
    output logic                                      collision
);

    localparam int unsigned RW      = ARRAY_SIZE * OUTPUT_DATA_WIDTH;
    localparam int unsigned BEATS   = RW / OUT_WIDTH;
    localparam int unsigned BEAT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W   = PTR_W + 1;
    localparam int unsigned ENTRY_W = 2 + 6 + RW;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HDR  = 2'd1,
        S_DATA = 2'd2
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [BEAT_W-1:0]    beat;
    logic [BEAT_W-1:0]    beat_next;

    logic [ENTRY_W-1:0]   mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [CNT_W-1:0]     count;
    logic [CNT_W-1:0]     count_next;

    logic                 push_req;
    logic                 push;
    logic                 pop;
    logic                 full;
    logic                 drop;
    logic                 multi_strobe;
    logic [ENTRY_W-1:0]   push_entry;
    logic                 done_seen;

    logic [ENTRY_W-1:0]   head;
    logic [1:0]           head_bank;
    logic [5:0]           head_addr;
    logic [RW-1:0]        head_data;
    logic [31:0]          hdr_word;

    // Strobe arbitration, a > b > c
    always_comb begin
        push_req     = sram_write_enable_a0 | sram_write_enable_b0 | sram_write_enable_c0;
        multi_strobe = (sram_write_enable_a0 & sram_write_enable_b0) |
                       (sram_write_enable_a0 & sram_write_enable_c0) |
                       (sram_write_enable_b0 & sram_write_enable_c0);
        push_entry   = '0;
        if (sram_write_enable_a0) begin
            push_entry = {2'd0, sram_waddr_a, sram_wdata_a};
        end else if (sram_write_enable_b0) begin
            push_entry = {2'd1, sram_waddr_b, sram_wdata_b};
        end else if (sram_write_enable_c0) begin
            push_entry = {2'd2, sram_waddr_c, sram_wdata_c};
        end
    end

    // A full FIFO still accepts a push when the head row retires this cycle
    always_comb begin
        full       = (count == CNT_W'(FIFO_DEPTH));
        pop        = (state == S_DATA) && m_ready && (beat == LAST_BEAT);
        push       = push_req && (!full || pop);
        drop       = push_req && full && !pop;
        count_next = count + CNT_W'(push) - CNT_W'(pop);
    end

    always_comb begin
        head      = mem[rd_ptr];
        head_bank = head[ENTRY_W-1 -: 2];
        head_addr = head[RW +: 6];
        head_data = head[RW-1:0];
        hdr_word  = {8'hA5, 14'b0, head_bank, 2'b0, head_addr};
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    always_ff @(posedge clk or negedge srstn) begin
        if (!srstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count_next;
        end
    end

    always_ff @(posedge clk or negedge srstn) begin
        if (!srstn) begin
            state <= S_IDLE;
            beat  <= '0;
        end else begin
            state <= state_next;
            beat  <= beat_next;
        end
    end

    // Stream FSM: stream outputs decode from FSM state and the FIFO head
    always_comb begin
        state_next = state;
        beat_next  = beat;
        m_valid    = 1'b0;
        m_last     = 1'b0;
        m_data     = '0;
        case (state)
            S_IDLE: begin
                if (count != '0) begin
                    state_next = S_HDR;
                end
            end
            S_HDR: begin
                m_valid = 1'b1;
                m_data  = OUT_WIDTH'(hdr_word);
                if (m_ready) begin
                    state_next = S_DATA;
                    beat_next  = '0;
                end
            end
            S_DATA: begin
                m_valid = 1'b1;
                m_data  = head_data[OUT_WIDTH*beat +: OUT_WIDTH];
                m_last  = (beat == LAST_BEAT);
                if (m_ready) begin
                    if (beat == LAST_BEAT) begin
                        state_next = (count_next != '0) ? S_HDR : S_IDLE;
                        beat_next  = '0;
                    end else begin
                        beat_next = beat + BEAT_W'(1);
                    end
                end
            end
            default: begin
                state_next = S_IDLE;
                beat_next  = '0;
            end
        endcase
    end

    always_comb begin
        drain_done = done_seen && (count == '0) && (state == S_IDLE) && !push_req;
    end

    // Completion latch and sticky error flags
    always_ff @(posedge clk or negedge srstn) begin
        if (!srstn) begin
            done_seen <= 1'b0;
            overflow  <= 1'b0;
            collision <= 1'b0;
        end else begin
            if (drain_done) begin
                done_seen <= 1'b0;
            end else if (tpu_done) begin
                done_seen <= 1'b1;
            end
            if (drop) begin
                overflow <= 1'b1;
            end
            if (multi_strobe) begin
                collision <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_tpu_result_drain.sv
// Self-checking bench for tpu_result_drain: directed scenarios plus random traffic
// scored against a row-queue model of the drain stream.
module tb_tpu_result_drain;

    localparam int unsigned ARRAY_SIZE = 8;
    localparam int unsigned ODW        = 16;
    localparam int unsigned OUT_WIDTH  = 32;
    localparam int unsigned DEPTH      = 4;
    localparam int unsigned RW         = ARRAY_SIZE * ODW;
    localparam int unsigned BEATS      = RW / OUT_WIDTH;

    typedef struct packed {
        logic [1:0]    bank;
        logic [5:0]    addr;
        logic [RW-1:0] data;
    } row_t;

    logic             clk;
    logic             srstn;
    logic             ae, be, ce;
    logic [RW-1:0]    ad, bd, cd;
    logic [5:0]       aa, ba, ca;
    logic             done_in;
    logic             m_valid;
    logic             ready;
    logic [OUT_WIDTH-1:0] m_data;
    logic             m_last;
    logic             drain_done;
    logic             overflow;
    logic             collision;

    int checks   = 0;
    int failures = 0;

    row_t        mq[$];
    int          w;
    bit          ovf_m, col_m, done_m;
    int          hs_count, pops, drains;
    logic [31:0] log_q[$];

    tpu_result_drain #(
        .ARRAY_SIZE(ARRAY_SIZE), .OUTPUT_DATA_WIDTH(ODW),
        .OUT_WIDTH(OUT_WIDTH), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .srstn(srstn),
        .sram_write_enable_a0(ae), .sram_write_enable_b0(be), .sram_write_enable_c0(ce),
        .sram_wdata_a(ad), .sram_wdata_b(bd), .sram_wdata_c(cd),
        .sram_waddr_a(aa), .sram_waddr_b(ba), .sram_waddr_c(ca),
        .tpu_done(done_in),
        .m_valid(m_valid), .m_ready(ready), .m_data(m_data), .m_last(m_last),
        .drain_done(drain_done), .overflow(overflow), .collision(collision)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired got=timeout exp=finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_word(input row_t r, input int idx);
        logic [RW-1:0] d;
        if (idx == 0) return {8'hA5, 14'b0, r.bank, 2'b0, r.addr};
        d = r.data;
        return d[32*(idx-1) +: 32];
    endfunction

    function automatic logic [RW-1:0] rnd_row();
        logic [RW-1:0] r;
        for (int i = 0; i < int'(RW / 32); i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    // One clock cycle: score outputs against the model, then advance the model
    task automatic step();
        bit   hs, exp_drain;
        int   n;
        row_t r;
        #1;
        check("overflow", overflow, ovf_m);
        check("collision", collision, col_m);
        exp_drain = done_m && (mq.size() == 0) && !(ae || be || ce);
        check("drain_done", drain_done, exp_drain);
        if (drain_done) drains++;
        if (m_valid) begin
            if (mq.size() == 0) begin
                check("valid_empty", m_valid, 1'b0);
            end else begin
                check("m_data", m_data, exp_word(mq[0], w));
                check("m_last", m_last, (w == int'(BEATS)));
            end
        end
        hs = m_valid && ready && (mq.size() > 0);
        if (hs) begin
            log_q.push_back(m_data);
            hs_count++;
            w++;
            if (w == int'(BEATS) + 1) begin
                void'(mq.pop_front());
                w = 0;
                pops++;
            end
        end
        n = int'(ae) + int'(be) + int'(ce);
        if (n > 1) col_m = 1'b1;
        if (n > 0) begin
            r = ae ? {2'd0, aa, ad} : (be ? {2'd1, ba, bd} : {2'd2, ca, cd});
            if (mq.size() < int'(DEPTH)) mq.push_back(r);
            else ovf_m = 1'b1;
        end
        done_m = exp_drain ? 1'b0 : (done_m || done_in);
        @(posedge clk);
        #1;
        ae = 0; be = 0; ce = 0; done_in = 0;
    endtask

    task automatic run_drain(input int limit, output int cyc);
        cyc = 0;
        while (mq.size() > 0 && cyc < limit) begin
            step();
            cyc++;
        end
        check("drain_timeout", 64'(mq.size()), 0);
    endtask

    task automatic do_reset();
        srstn = 0;
        ae = 0; be = 0; ce = 0; done_in = 0; ready = 0;
        mq.delete(); log_q.delete();
        w = 0; ovf_m = 0; col_m = 0; done_m = 0;
        hs_count = 0; pops = 0; drains = 0;
        #1;
        check("rst_m_valid", m_valid, 0);
        check("rst_m_last", m_last, 0);
        check("rst_m_data", m_data, 0);
        check("rst_drain_done", drain_done, 0);
        check("rst_overflow", overflow, 0);
        check("rst_collision", collision, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        srstn = 1;
        @(posedge clk);
        #1;
    endtask

    logic [31:0] t1_words [5];
    logic [RW-1:0] seq_row;
    int cyc;
    bit injected;

    initial begin
        t1_words = '{32'hA5000005, 32'h00020001, 32'h00040003, 32'h00060005, 32'h00080007};
        for (int i = 0; i < int'(ARRAY_SIZE); i++) seq_row[ODW*i +: ODW] = ODW'(i + 1);
        aa = 0; ba = 0; ca = 0; ad = '0; bd = '0; cd = '0;
        ae = 0; be = 0; ce = 0; done_in = 0; ready = 0; srstn = 0;

        // Single row with latency check
        do_reset();
        ready = 1;
        ae = 1; aa = 6'd5; ad = seq_row;
        step();
        check("t1_lat_n", m_valid, 0);
        step();
        check("t1_lat_n1", m_valid, 1);
        run_drain(20, cyc);
        check("t1_words_n", 64'(log_q.size()), 5);
        for (int i = 0; i < 5 && i < log_q.size(); i++) check("t1_word", log_q[i], t1_words[i]);

        // Backpressure, ready pattern 1,0,0,1,...
        do_reset();
        ae = 1; aa = 6'd5; ad = seq_row;
        step();
        for (int c = 0; c < 60 && hs_count < 5; c++) begin
            ready = (c % 3 == 0);
            step();
        end
        ready = 1;
        repeat (4) step();
        check("t2_handshakes", 64'(hs_count), 5);
        for (int i = 0; i < 5 && i < log_q.size(); i++) check("t2_word", log_q[i], t1_words[i]);

        // Overflow: five b0 strobes into a stalled FIFO
        do_reset();
        for (int i = 0; i < 5; i++) begin
            be = 1; ba = 6'(i); bd = rnd_row();
            step();
        end
        check("t3_overflow", overflow, 1);
        ready = 1;
        run_drain(40, cyc);
        check("t3_rows", 64'(pops), 4);
        check("t3_cycles", 64'(cyc), 64'(4 * (BEATS + 1)));
        for (int i = 0; i < 4 && (i * 5) < log_q.size(); i++)
            check("t3_hdr", log_q[i*5], {8'hA5, 14'b0, 2'd1, 2'b0, 6'(i)});

        // Collision: a0 and c0 together
        do_reset();
        ready = 1;
        ae = 1; aa = 6'd7; ad = rnd_row();
        ce = 1; ca = 6'd9; cd = rnd_row();
        step();
        run_drain(20, cyc);
        step();
        check("t4_collision", collision, 1);
        check("t4_rows", 64'(pops), 1);
        if (log_q.size() > 0) check("t4_hdr", log_q[0], 32'hA5000007);

        // Full FIFO with simultaneous final-beat pop and push
        do_reset();
        for (int i = 0; i < 4; i++) begin
            ae = 1; aa = 6'(10 + i); ad = rnd_row();
            step();
        end
        ready = 1;
        injected = 0;
        for (int c = 0; c < 60 && (mq.size() > 0 || !injected); c++) begin
            if (!injected && mq.size() == int'(DEPTH) && w == int'(BEATS)) begin
                ae = 1; aa = 6'h3F; ad = rnd_row();
                injected = 1;
            end
            step();
        end
        check("t5_overflow", overflow, 0);
        check("t5_rows", 64'(pops), 5);
        if (log_q.size() >= 5) check("t5_last_hdr", log_q[log_q.size()-5], 32'hA500003F);

        // Completion with two buffered rows
        do_reset();
        ae = 1; aa = 6'd1; ad = rnd_row(); step();
        ae = 1; aa = 6'd2; ad = rnd_row(); done_in = 1; step();
        ready = 1;
        run_drain(30, cyc);
        #1;
        check("t6_drain_timing", drain_done, 1);
        repeat (5) step();
        check("t6_drain_count", 64'(drains), 1);

        // Reset mid-row after a tpu_done pulse
        ae = 1; aa = 6'd3; ad = rnd_row(); done_in = 1; step();
        repeat (3) step();
        check("t6_midrow_valid", m_valid, 1);
        do_reset();
        ready = 1;
        repeat (10) step();
        check("t6_no_drain", 64'(drains), 0);

        // Random traffic
        do_reset();
        for (int c = 0; c < 600; c++) begin
            ready = ($urandom_range(0, 3) != 0);
            ae = ($urandom_range(0, 5) == 0); aa = 6'($urandom); ad = rnd_row();
            be = ($urandom_range(0, 5) == 0); ba = 6'($urandom); bd = rnd_row();
            ce = ($urandom_range(0, 5) == 0); ca = 6'($urandom); cd = rnd_row();
            done_in = ($urandom_range(0, 39) == 0);
            step();
        end
        ready = 1;
        run_drain(100, cyc);
        repeat (3) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
